// File: rtl/step_run_pkg.sv
// Shared types and constants for the step/run clock-enable controller.
package step_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  // The unused encoding 2'b11 behaves exactly like count mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_COUNT : m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable divider: counts 0..term and flags a tick on the terminal value.
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             freeze,
  input  logic [DIV_W-1:0] term,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] count;

  assign tick = (count == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!freeze) begin
      count <= tick ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/step_run_ctrl.sv
// Cycle-run controller: issues counted, free-running or single-stepped
// clock-enable ticks on a set of channels, with a programmable divide ratio.
module step_run_ctrl
  import step_run_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  cycles,
  input  logic [DIV_W-1:0]  div,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              step,
  input  logic              halt,
  output logic [NUM_CH-1:0] ce,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cyc_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  cycles_q;
  logic [DIV_W-1:0]  div_q;
  logic [NUM_CH-1:0] mask_q;
  logic              step_pend;
  logic              presc_tick;
  logic              presc_freeze;
  logic              accept;
  logic              tick;
  logic              last_tick;

  assign accept       = (state == IDLE) && start;
  assign presc_freeze = (state != RUN) || (mode_q == MODE_STEP);

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .freeze (presc_freeze),
    .term   (div_q),
    .tick   (presc_tick)
  );

  // Ticks are derived from registered state only, so ce has no input path.
  assign tick      = (state == RUN) &&
                     ((mode_q == MODE_STEP) ? step_pend : presc_tick);
  assign last_tick = (mode_q == MODE_COUNT) && (cyc_count == cycles_q - CNT_ONE);

  assign ce   = tick ? mask_q : '0;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((norm_mode(mode) == MODE_COUNT) && (cycles == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (halt || (tick && last_tick)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_COUNT;
      cycles_q <= '0;
      div_q    <= '0;
      mask_q   <= '0;
    end else if (accept) begin
      mode_q   <= norm_mode(mode);
      cycles_q <= cycles;
      div_q    <= div;
      mask_q   <= ch_mask;
    end
  end

  // A pending step is always consumed in the very next cycle, so following
  // the step input directly gives one tick per sampled-high step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pend <= 1'b0;
    end else if ((state == RUN) && (mode_q == MODE_STEP)) begin
      step_pend <= step;
    end else begin
      step_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_count <= '0;
    end else if (accept) begin
      cyc_count <= '0;
    end else if (tick) begin
      cyc_count <= cyc_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed self-checking bench for step_run_ctrl, including a narrow-counter
// instance for the wrap-around case.
module tb_step_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] cycles;
  logic [7:0]  div;
  logic [1:0]  ch_mask;
  logic        step;
  logic        halt;
  logic [1:0]  ce;
  logic        busy;
  logic        done;
  logic [15:0] cyc_count;

  logic [3:0]  cycles4;
  logic [1:0]  ce4;
  logic        busy4;
  logic        done4;
  logic [3:0]  cyc_count4;

  int errors = 0;
  int checks = 0;

  assign cycles4 = cycles[3:0];

  step_run_ctrl #(.CNT_W(16), .DIV_W(8), .NUM_CH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .cycles    (cycles),
    .div       (div),
    .ch_mask   (ch_mask),
    .step      (step),
    .halt      (halt),
    .ce        (ce),
    .busy      (busy),
    .done      (done),
    .cyc_count (cyc_count)
  );

  step_run_ctrl #(.CNT_W(4), .DIV_W(8), .NUM_CH(2)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .cycles    (cycles4),
    .div       (div),
    .ch_mask   (ch_mask),
    .step      (step),
    .halt      (halt),
    .ce        (ce4),
    .busy      (busy4),
    .done      (done4),
    .cyc_count (cyc_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] m,
                               input logic [15:0] cyc, input logic [7:0] d,
                               input logic [1:0] msk);
    start   = s;
    mode    = m;
    cycles  = cyc;
    div     = d;
    ch_mask = msk;
  endtask

  // Cycle k=1 is the first cycle after the start edge; pulses land every d+1 cycles.
  task automatic runCount(input string tag, input logic [1:0] m, input int n,
                          input int d, input logic [1:0] msk);
    int period;
    int last;
    int exp_cnt;
    period = d + 1;
    last   = period * n;
    applyStimulus(1'b1, m, n[15:0], d[7:0], msk);
    for (int k = 1; k <= last + 3; k++) begin
      nextCycle();
      if (k == 1) start = 1'b0;
      exp_cnt = ((k - 1) / period < n) ? (k - 1) / period : n;
      checkOutput($sformatf("%s ce k=%0d", tag, k), ce,
                  ((k % period == 0) && (k <= last)) ? msk : 2'b00);
      checkOutput($sformatf("%s done k=%0d", tag, k), done, k == last + 1);
      checkOutput($sformatf("%s busy k=%0d", tag, k), busy, k <= last + 1);
      checkOutput($sformatf("%s cnt k=%0d", tag, k), cyc_count, exp_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step  = 1'b0;
    halt  = 1'b0;
    applyStimulus(1'b0, 2'b00, 16'd0, 8'd0, 2'b00);
    repeat (2) nextCycle();
    checkOutput("reset ce", ce, 2'b00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset cnt", cyc_count, 16'd0);
    rst_n = 1'b1;
    nextCycle();

    runCount("cnt3", 2'b00, 3, 0, 2'b11);
    runCount("cnt4", 2'b11, 4, 2, 2'b01);
    runCount("cnt0", 2'b00, 0, 5, 2'b11);

    // Free-run div=1, a start with new settings mid-run, halt in the 5th tick cycle.
    applyStimulus(1'b1, 2'b01, 16'd2, 8'd1, 2'b10);
    for (int k = 1; k <= 14; k++) begin
      nextCycle();
      if (k == 1) start = 1'b0;
      if (k == 3) applyStimulus(1'b1, 2'b00, 16'd9, 8'd0, 2'b01);
      if (k == 4) start = 1'b0;
      if (k == 11) halt = 1'b0;
      checkOutput($sformatf("free ce k=%0d", k), ce,
                  ((k % 2 == 0) && (k <= 10)) ? 2'b10 : 2'b00);
      checkOutput($sformatf("free done k=%0d", k), done, k == 11);
      checkOutput($sformatf("free busy k=%0d", k), busy, k <= 11);
      checkOutput($sformatf("free cnt k=%0d", k), cyc_count,
                  ((k - 1) / 2 < 5) ? (k - 1) / 2 : 5);
      if (k == 10) halt = 1'b1;
    end

    // Single steps at cycles 2, 6, 10, then step held through 14 and 15.
    begin
      int exp_cnt;
      logic pulse;
      exp_cnt = 0;
      applyStimulus(1'b1, 2'b10, 16'd0, 8'd7, 2'b11);
      for (int k = 1; k <= 20; k++) begin
        nextCycle();
        if (k == 1) start = 1'b0;
        pulse = (k == 3) || (k == 7) || (k == 11) || (k == 15) || (k == 16);
        checkOutput($sformatf("step ce k=%0d", k), ce, pulse ? 2'b11 : 2'b00);
        checkOutput($sformatf("step cnt k=%0d", k), cyc_count, exp_cnt);
        checkOutput($sformatf("step done k=%0d", k), done, k == 19);
        checkOutput($sformatf("step busy k=%0d", k), busy, k <= 19);
        if (pulse) exp_cnt++;
        step = (k == 2) || (k == 6) || (k == 10) || (k == 14) || (k == 15);
        halt = (k == 18);
      end
      step = 1'b0;
      halt = 1'b0;
    end

    // Asynchronous reset in the middle of a free run.
    applyStimulus(1'b1, 2'b01, 16'd0, 8'd0, 2'b11);
    nextCycle();
    start = 1'b0;
    repeat (3) nextCycle();
    checkOutput("prereset cnt", cyc_count, 16'd3);
    checkOutput("prereset ce", ce, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset ce", ce, 2'b00);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset done", done, 1'b0);
    checkOutput("midreset cnt", cyc_count, 16'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      checkOutput($sformatf("postreset done k=%0d", k), done, 1'b0);
      checkOutput($sformatf("postreset busy k=%0d", k), busy, 1'b0);
      checkOutput($sformatf("postreset ce k=%0d", k), ce, 2'b00);
    end

    // 4-bit counter: 17 ticks then halt in the 17th tick cycle wraps to 1.
    applyStimulus(1'b1, 2'b01, 16'd0, 8'd0, 2'b01);
    for (int k = 1; k <= 19; k++) begin
      nextCycle();
      if (k == 1) start = 1'b0;
      if (k == 18) halt = 1'b0;
      checkOutput($sformatf("wrap ce k=%0d", k), ce4, (k <= 17) ? 2'b01 : 2'b00);
      checkOutput($sformatf("wrap done k=%0d", k), done4, k == 18);
      if (k == 17) checkOutput("wrap cnt k=17", cyc_count4, 4'd0);
      if (k == 18) checkOutput("wrap cnt k=18", cyc_count4, 4'd1);
      if (k == 19) checkOutput("wrap busy k=19", busy4, 1'b0);
      if (k == 17) halt = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
